// File: rtl/pkt_mem_reader_pkg.sv
// Shared constants for the packet memory reader: FSM state encoding and default widths.
package pkt_mem_reader_pkg;

  localparam int unsigned DEF_DATA_WIDTH = 64;
  localparam int unsigned DEF_ADDR_WIDTH = 8;
  localparam int unsigned FIFO_DEPTH     = 2;
  localparam int unsigned STATE_WIDTH    = 2;

  localparam logic [STATE_WIDTH-1:0] ST_IDLE  = 2'b00;
  localparam logic [STATE_WIDTH-1:0] ST_READ  = 2'b01;
  localparam logic [STATE_WIDTH-1:0] ST_DRAIN = 2'b10;
  localparam logic [STATE_WIDTH-1:0] ST_DONE  = 2'b11;

endpackage

// File: rtl/pkt_rd_skid_fifo.sv
// Two-entry output FIFO between the packet memory read port and the downstream stage.
// Head word is presented directly from storage; pushes and pops may coincide.
module pkt_rd_skid_fifo
  import pkt_mem_reader_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned CTRL_WIDTH = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic [CTRL_WIDTH-1:0] push_ctrl,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] head_data,
  output logic [CTRL_WIDTH-1:0] head_ctrl,
  output logic [1:0]            count,
  output logic                  empty
);

  logic [DATA_WIDTH-1:0] data_q [FIFO_DEPTH];
  logic [CTRL_WIDTH-1:0] ctrl_q [FIFO_DEPTH];
  logic                  wr_ptr_q;
  logic                  rd_ptr_q;
  logic [1:0]            count_q;
  logic                  push_ok;
  logic                  pop_ok;

  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign pop_ok  = pop && (count_q != 2'd0);
  assign push_ok = push && ((count_q != 2'(FIFO_DEPTH)) || pop_ok);

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
        data_q[i] <= '0;
        ctrl_q[i] <= '0;
      end
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (push_ok) begin
        data_q[wr_ptr_q] <= push_data;
        ctrl_q[wr_ptr_q] <= push_ctrl;
        wr_ptr_q         <= ~wr_ptr_q;
      end
      if (pop_ok) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
    end
  end

  assign head_data = data_q[rd_ptr_q];
  assign head_ctrl = ctrl_q[rd_ptr_q];
  assign count     = count_q;
  assign empty     = (count_q == 2'd0);

endmodule

// File: rtl/pkt_mem_reader.sv
// Streams a stored packet out of packet memory into the next pipeline stage.
// Optional statistics counters (pkt_count, word_count) are built when PKT_RD_STATS_EN is defined.
module pkt_mem_reader
  import pkt_mem_reader_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned CTRL_WIDTH = DATA_WIDTH / 8,
  parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  packet_rdy,
  input  logic [ADDR_WIDTH-1:0] packet_start_addr,
  input  logic [ADDR_WIDTH-1:0] packet_end_addr,
  output logic [ADDR_WIDTH-1:0] mem_rd_addr,
  output logic                  mem_rd_en,
  input  logic [DATA_WIDTH-1:0] mem_rd_data,
  input  logic [CTRL_WIDTH-1:0] mem_rd_ctrl,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [CTRL_WIDTH-1:0] out_ctrl,
  output logic                  out_wr,
  input  logic                  out_rdy,
  output logic                  pkt_done,
  output logic                  busy
`ifdef PKT_RD_STATS_EN
  ,
  output logic [31:0]           pkt_count,
  output logic [31:0]           word_count
`endif
);

  logic [STATE_WIDTH-1:0] state_q;
  logic [STATE_WIDTH-1:0] state_d;
  logic [ADDR_WIDTH-1:0]  rd_addr_q;
  logic [ADDR_WIDTH-1:0]  end_addr_q;
  logic                   rd_pend_q;
  logic [1:0]             fifo_count;
  logic                   fifo_empty;
  logic                   rd_issue_c;
  logic                   last_rd_c;
  logic                   last_wr_c;

  // Next-state and read-issue decode.
  // A read is issued only if the word it returns is guaranteed a FIFO slot, counting the
  // slot freed by a pop in this same cycle so streaming runs at one word per cycle.
  always_comb begin
    state_d    = state_q;
    rd_issue_c = 1'b0;
    last_rd_c  = 1'b0;
    last_wr_c  = 1'b0;
    out_wr     = !fifo_empty && out_rdy;
    case (state_q)
      ST_IDLE: begin
        if (packet_rdy) begin
          state_d = ST_READ;
        end
      end
      ST_READ: begin
        rd_issue_c = (3'(fifo_count) + 3'(rd_pend_q)) < (3'd2 + 3'(out_wr));
        last_rd_c  = rd_issue_c && (rd_addr_q == end_addr_q);
        if (last_rd_c) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        last_wr_c = out_wr && (fifo_count == 2'd1) && !rd_pend_q;
        if (last_wr_c) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Address window is captured once per packet; the read pointer wraps naturally.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_addr_q  <= '0;
      end_addr_q <= '0;
      rd_pend_q  <= 1'b0;
    end else begin
      rd_pend_q <= rd_issue_c;
      if ((state_q == ST_IDLE) && packet_rdy) begin
        rd_addr_q  <= packet_start_addr;
        end_addr_q <= packet_end_addr;
      end else if (rd_issue_c && !last_rd_c) begin
        rd_addr_q <= rd_addr_q + ADDR_WIDTH'(1);
      end
    end
  end

  pkt_rd_skid_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .CTRL_WIDTH (CTRL_WIDTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (rd_pend_q),
    .push_data (mem_rd_data),
    .push_ctrl (mem_rd_ctrl),
    .pop       (out_wr),
    .head_data (out_data),
    .head_ctrl (out_ctrl),
    .count     (fifo_count),
    .empty     (fifo_empty)
  );

  assign mem_rd_en   = rd_issue_c;
  assign mem_rd_addr = rd_addr_q;
  assign pkt_done    = (state_q == ST_DONE);
  assign busy        = (state_q != ST_IDLE);

`ifdef PKT_RD_STATS_EN
  // Free-running statistics, wrapping at 2^32.
  always_ff @(posedge clk) begin
    if (reset) begin
      pkt_count  <= 32'd0;
      word_count <= 32'd0;
    end else begin
      if (pkt_done) begin
        pkt_count <= pkt_count + 32'd1;
      end
      if (out_wr) begin
        word_count <= word_count + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_pkt_mem_reader.sv
// Directed self-checking bench for pkt_mem_reader with a one-cycle-latency memory model.
module tb_pkt_mem_reader;

  logic        clk;
  logic        reset;
  logic        packet_rdy;
  logic [7:0]  packet_start_addr;
  logic [7:0]  packet_end_addr;
  logic [7:0]  mem_rd_addr;
  logic        mem_rd_en;
  logic [63:0] mem_rd_data;
  logic [7:0]  mem_rd_ctrl;
  logic [63:0] out_data;
  logic [7:0]  out_ctrl;
  logic        out_wr;
  logic        out_rdy;
  logic        pkt_done;
  logic        busy;
`ifdef PKT_RD_STATS_EN
  logic [31:0] pkt_count;
  logic [31:0] word_count;
`endif

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int done_cnt = 0;
  int done_cyc = 0;
  int first_wr_cyc = 0;
  int last_wr_cyc = 0;
  int wr_no_rdy = 0;
  int ovf = 0;
  int rd_total = 0;
  int wr_total = 0;
  logic [71:0] got_q[$];
  logic [5:0]  bp_pat = 6'b101001;

  pkt_mem_reader dut (
    .clk               (clk),
    .reset             (reset),
    .packet_rdy        (packet_rdy),
    .packet_start_addr (packet_start_addr),
    .packet_end_addr   (packet_end_addr),
    .mem_rd_addr       (mem_rd_addr),
    .mem_rd_en         (mem_rd_en),
    .mem_rd_data       (mem_rd_data),
    .mem_rd_ctrl       (mem_rd_ctrl),
    .out_data          (out_data),
    .out_ctrl          (out_ctrl),
    .out_wr            (out_wr),
    .out_rdy           (out_rdy),
    .pkt_done          (pkt_done),
    .busy              (busy)
`ifdef PKT_RD_STATS_EN
    ,
    .pkt_count         (pkt_count),
    .word_count        (word_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] exp_data(input logic [7:0] a);
    return {4{a, ~a}};
  endfunction

  function automatic logic [7:0] exp_ctrl(input logic [7:0] a);
    return a ^ 8'h5A;
  endfunction

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mem_rd_en) begin
      mem_rd_data <= exp_data(mem_rd_addr);
      mem_rd_ctrl <= exp_ctrl(mem_rd_addr);
    end
  end

  // Observer: records delivered words and protocol events on the falling edge.
  always @(negedge clk) begin
    if (reset) begin
      rd_total = 0;
      wr_total = 0;
    end else begin
      if (mem_rd_en) rd_total++;
      if (out_wr) begin
        if (got_q.size() == 0) first_wr_cyc = cyc;
        got_q.push_back({out_data, out_ctrl});
        last_wr_cyc = cyc;
        wr_total++;
        if (!out_rdy) wr_no_rdy++;
      end
      if (rd_total - wr_total > 2) ovf++;
      if (pkt_done) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
  end

  task automatic run_pkt(input logic [7:0] s, input logic [7:0] e, input bit bp,
                         output bit to, output int start_cyc);
    int n0;
    got_q.delete();
    n0 = done_cnt;
    to = 1'b1;
    @(posedge clk); #1;
    packet_rdy = 1'b1;
    packet_start_addr = s;
    packet_end_addr = e;
    out_rdy = 1'b1;
    start_cyc = cyc;
    @(posedge clk); #1;
    packet_rdy = 1'b0;
    packet_start_addr = ~s;
    packet_end_addr = ~e;
    for (int k = 1; k < 400; k++) begin
      out_rdy = bp ? bp_pat[k % 6] : 1'b1;
      if (done_cnt != n0) begin
        to = 1'b0;
        break;
      end
      @(posedge clk); #1;
    end
    out_rdy = 1'b1;
  endtask

  task automatic test_reset();
    checks++; if (out_wr !== 1'b0) begin errors++; $display("FAIL reset_out_wr got %b exp 0", out_wr); end
    checks++; if (mem_rd_en !== 1'b0) begin errors++; $display("FAIL reset_mem_rd_en got %b exp 0", mem_rd_en); end
    checks++; if (pkt_done !== 1'b0) begin errors++; $display("FAIL reset_pkt_done got %b exp 0", pkt_done); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    checks++; if (mem_rd_addr !== 8'h00) begin errors++; $display("FAIL reset_mem_rd_addr got %h exp 00", mem_rd_addr); end
    checks++; if (out_data !== 64'h0) begin errors++; $display("FAIL reset_out_data got %h exp 0", out_data); end
    checks++; if (out_ctrl !== 8'h00) begin errors++; $display("FAIL reset_out_ctrl got %h exp 00", out_ctrl); end
  endtask

  task automatic test_basic();
    bit to;
    int sc;
    int d0;
    logic [7:0] a;
    d0 = done_cnt;
    run_pkt(8'h10, 8'h13, 1'b0, to, sc);
    checks++; if (to !== 1'b0) begin errors++; $display("FAIL basic_timeout got %b exp 0", to); end
    checks++; if (got_q.size() != 4) begin errors++; $display("FAIL basic_count got %0d exp 4", got_q.size()); end
    for (int i = 0; i < 4 && i < got_q.size(); i++) begin
      a = 8'h10 + 8'(i);
      checks++;
      if (got_q[i] !== {exp_data(a), exp_ctrl(a)})
        begin errors++; $display("FAIL basic_word%0d got %h exp %h", i, got_q[i], {exp_data(a), exp_ctrl(a)}); end
    end
    checks++; if (done_cyc != last_wr_cyc + 1) begin errors++; $display("FAIL basic_done_timing got %0d exp %0d", done_cyc, last_wr_cyc + 1); end
    checks++; if (done_cnt != d0 + 1) begin errors++; $display("FAIL basic_done_count got %0d exp %0d", done_cnt, d0 + 1); end
    checks++; if (last_wr_cyc - first_wr_cyc != 3) begin errors++; $display("FAIL basic_throughput got %0d exp 3", last_wr_cyc - first_wr_cyc); end
    checks++; if (first_wr_cyc - (sc + 1) < 2) begin errors++; $display("FAIL basic_latency got %0d exp >=2", first_wr_cyc - (sc + 1)); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy_after got %b exp 0", busy); end
  endtask

  task automatic test_wrap();
    bit to;
    int sc;
    logic [7:0] addrs [4];
    addrs = '{8'hFE, 8'hFF, 8'h00, 8'h01};
    run_pkt(8'hFE, 8'h01, 1'b0, to, sc);
    checks++; if (to !== 1'b0) begin errors++; $display("FAIL wrap_timeout got %b exp 0", to); end
    checks++; if (got_q.size() != 4) begin errors++; $display("FAIL wrap_count got %0d exp 4", got_q.size()); end
    for (int i = 0; i < 4 && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== {exp_data(addrs[i]), exp_ctrl(addrs[i])})
        begin errors++; $display("FAIL wrap_word%0d got %h exp %h", i, got_q[i], {exp_data(addrs[i]), exp_ctrl(addrs[i])}); end
    end
  endtask

  task automatic test_single();
    bit to;
    int sc;
    int d0;
    d0 = done_cnt;
    run_pkt(8'h20, 8'h20, 1'b0, to, sc);
    checks++; if (to !== 1'b0) begin errors++; $display("FAIL single_timeout got %b exp 0", to); end
    checks++; if (got_q.size() != 1) begin errors++; $display("FAIL single_count got %0d exp 1", got_q.size()); end
    if (got_q.size() > 0) begin
      checks++;
      if (got_q[0] !== {64'h20DF20DF20DF20DF, 8'h7A})
        begin errors++; $display("FAIL single_word got %h exp %h", got_q[0], {64'h20DF20DF20DF20DF, 8'h7A}); end
    end
    checks++; if (done_cnt != d0 + 1) begin errors++; $display("FAIL single_done_count got %0d exp %0d", done_cnt, d0 + 1); end
  endtask

  task automatic test_backpressure();
    bit to;
    int sc;
    logic [7:0] a;
    wr_no_rdy = 0;
    ovf = 0;
    run_pkt(8'h70, 8'h77, 1'b1, to, sc);
    checks++; if (to !== 1'b0) begin errors++; $display("FAIL bp_timeout got %b exp 0", to); end
    checks++; if (got_q.size() != 8) begin errors++; $display("FAIL bp_count got %0d exp 8", got_q.size()); end
    for (int i = 0; i < 8 && i < got_q.size(); i++) begin
      a = 8'h70 + 8'(i);
      checks++;
      if (got_q[i] !== {exp_data(a), exp_ctrl(a)})
        begin errors++; $display("FAIL bp_word%0d got %h exp %h", i, got_q[i], {exp_data(a), exp_ctrl(a)}); end
    end
    checks++; if (wr_no_rdy != 0) begin errors++; $display("FAIL bp_wr_without_rdy got %0d exp 0", wr_no_rdy); end
    checks++; if (ovf != 0) begin errors++; $display("FAIL bp_fifo_overrun got %0d exp 0", ovf); end
  endtask

  task automatic test_reset_abort();
    bit to;
    int sc;
    int n0;
    logic [7:0] a;
    got_q.delete();
    n0 = done_cnt;
    @(posedge clk); #1;
    packet_rdy = 1'b1;
    packet_start_addr = 8'h50;
    packet_end_addr = 8'h57;
    out_rdy = 1'b1;
    @(posedge clk); #1;
    packet_rdy = 1'b0;
    for (int k = 0; k < 100; k++) begin
      if (got_q.size() >= 3) break;
      @(posedge clk); #1;
    end
    checks++; if (got_q.size() < 3) begin errors++; $display("FAIL abort_reach3 got %0d exp >=3", got_q.size()); end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    checks++; if (out_wr !== 1'b0) begin errors++; $display("FAIL abort_out_wr got %b exp 0", out_wr); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy got %b exp 0", busy); end
    repeat (10) @(posedge clk);
    #1;
    checks++; if (done_cnt != n0) begin errors++; $display("FAIL abort_no_done got %0d exp %0d", done_cnt, n0); end
    run_pkt(8'h60, 8'h62, 1'b0, to, sc);
    checks++; if (to !== 1'b0) begin errors++; $display("FAIL abort_next_timeout got %b exp 0", to); end
    checks++; if (got_q.size() != 3) begin errors++; $display("FAIL abort_next_count got %0d exp 3", got_q.size()); end
    for (int i = 0; i < 3 && i < got_q.size(); i++) begin
      a = 8'h60 + 8'(i);
      checks++;
      if (got_q[i] !== {exp_data(a), exp_ctrl(a)})
        begin errors++; $display("FAIL abort_next_word%0d got %h exp %h", i, got_q[i], {exp_data(a), exp_ctrl(a)}); end
    end
  endtask

  task automatic test_back_to_back();
    int n0;
    int size1;
    bit seen1;
    logic [7:0] addrs [8];
    addrs = '{8'h30, 8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h40, 8'h41};
    got_q.delete();
    n0 = done_cnt;
    size1 = -1;
    seen1 = 1'b0;
    @(posedge clk); #1;
    packet_rdy = 1'b1;
    packet_start_addr = 8'h30;
    packet_end_addr = 8'h35;
    out_rdy = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    packet_start_addr = 8'h40;
    packet_end_addr = 8'h41;
    for (int k = 0; k < 400; k++) begin
      if (!seen1 && done_cnt == n0 + 1) begin
        seen1 = 1'b1;
        size1 = got_q.size();
      end
      if (done_cnt >= n0 + 2) break;
      @(posedge clk); #1;
    end
    packet_rdy = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    checks++; if (size1 != 6) begin errors++; $display("FAIL b2b_first_count got %0d exp 6", size1); end
    checks++; if (done_cnt != n0 + 2) begin errors++; $display("FAIL b2b_done_count got %0d exp %0d", done_cnt, n0 + 2); end
    checks++; if (got_q.size() != 8) begin errors++; $display("FAIL b2b_total_count got %0d exp 8", got_q.size()); end
    for (int i = 0; i < 8 && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== {exp_data(addrs[i]), exp_ctrl(addrs[i])})
        begin errors++; $display("FAIL b2b_word%0d got %h exp %h", i, got_q[i], {exp_data(addrs[i]), exp_ctrl(addrs[i])}); end
    end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_idle_after got %b exp 0", busy); end
  endtask

  initial begin
    reset = 1'b1;
    packet_rdy = 1'b0;
    packet_start_addr = 8'h00;
    packet_end_addr = 8'h00;
    out_rdy = 1'b1;
    mem_rd_data = 64'h0;
    mem_rd_ctrl = 8'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    test_reset();
    @(posedge clk); #1;
    reset = 1'b0;
    test_basic();
    test_wrap();
    test_single();
    test_backpressure();
    test_reset_abort();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1, "watchdog expired");
  end

endmodule
